// File: rtl/scalar_reduce.sv
// scalar_reduce: folds the active elements of a vector, delivered as
// 128-bit beats of four 32-bit lane slots, into one SEW-wide scalar.
// The scalar is returned sign- or zero-extended to 32 bits over a
// valid/ready handshake.
module scalar_reduce #(
    parameter  int MAX_VL = 64,
    localparam int VLW    = $clog2(MAX_VL + 1)
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [1:0]      vsew,
    input  logic            us,
    input  logic [VLW-1:0]  vl,
    input  logic [31:0]     init_in,
    input  logic [127:0]    lane_data,
    input  logic            lane_valid,
    output logic            lane_ready,
    output logic            busy,
    output logic [31:0]     result,
    output logic            result_valid,
    input  logic            result_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;

    logic [2:0]      r_op;
    logic [1:0]      r_sew;
    logic            r_us;
    logic [VLW-1:0]  r_rem;
    logic [31:0]     r_acc;

    logic            r_laneReady;
    logic            r_busy;
    logic            r_resultValid;

    logic [VLW-1:0]  w_count;
    logic [VLW-1:0]  w_remNext;
    logic [31:0]     w_accNext;

    // Keeps only the low SEW bits; an encoding of 3 behaves as 32-bit.
    function automatic logic [31:0] sewMask(input logic [1:0] f_sew);
        case (f_sew)
            2'd0:    sewMask = 32'h0000_00FF;
            2'd1:    sewMask = 32'h0000_FFFF;
            default: sewMask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Widens an SEW-wide value to 32 bits, zero-extending when unsigned.
    function automatic logic [31:0] extendSew(input logic [31:0] f_val,
                                              input logic [1:0]  f_sew,
                                              input logic        f_us);
        case (f_sew)
            2'd0:    extendSew = {{24{~f_us & f_val[7]}},  f_val[7:0]};
            2'd1:    extendSew = {{16{~f_us & f_val[15]}}, f_val[15:0]};
            default: extendSew = f_val;
        endcase
    endfunction

    // One reduction step: combines acc with a single element in SEW bits.
    // For max/min, acc is replaced only on a strict win, so ties keep acc.
    function automatic logic [31:0] applyOp(input logic [2:0]  f_op,
                                            input logic [1:0]  f_sew,
                                            input logic        f_us,
                                            input logic [31:0] f_acc,
                                            input logic [31:0] f_elem);
        logic [31:0] v_a;
        logic [31:0] v_b;
        logic        v_bGt;
        logic        v_bLt;
        logic [31:0] v_res;
        v_a = extendSew(f_acc, f_sew, f_us);
        v_b = extendSew(f_elem, f_sew, f_us);
        if (f_us) begin
            v_bGt = (v_b > v_a);
            v_bLt = (v_b < v_a);
        end else begin
            v_bGt = ($signed(v_b) > $signed(v_a));
            v_bLt = ($signed(v_b) < $signed(v_a));
        end
        case (f_op)
            3'd1:    v_res = f_acc & f_elem;
            3'd2:    v_res = f_acc | f_elem;
            3'd3:    v_res = f_acc ^ f_elem;
            3'd4:    v_res = v_bGt ? f_elem : f_acc;
            3'd5:    v_res = v_bLt ? f_elem : f_acc;
            default: v_res = f_acc + f_elem;
        endcase
        applyOp = v_res & sewMask(f_sew);
    endfunction

    // Folds the active slots of the current beat into acc in lane order;
    // a slot is active while the remaining count exceeds its index.
    always_comb begin
        logic [31:0] v_acc;
        v_acc = r_acc;
        for (int i = 0; i < 4; i++) begin
            if (r_rem > VLW'(i)) begin
                v_acc = applyOp(r_op, r_sew, r_us, v_acc,
                                lane_data[32*i +: 32] & sewMask(r_sew));
            end
        end
        w_accNext = v_acc;
        w_count   = (r_rem > VLW'(4)) ? VLW'(4) : r_rem;
        w_remNext = r_rem - w_count;
    end

    // Next-state decode for the IDLE -> ACCUM -> DONE sequence.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = (vl == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (lane_valid && (w_remNext == '0)) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // State register plus registered decodes of the next state, so the
    // handshake outputs never depend combinationally on lane_valid.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_IDLE;
            r_laneReady   <= 1'b0;
            r_busy        <= 1'b0;
            r_resultValid <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_laneReady   <= (w_stateNext == S_ACCUM);
            r_busy        <= (w_stateNext != S_IDLE);
            r_resultValid <= (w_stateNext == S_DONE);
        end
    end

    // Latches the configuration on an accepted start and advances the
    // accumulator and remaining count only on accepted beats.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_op  <= 3'd0;
            r_sew <= 2'd0;
            r_us  <= 1'b0;
            r_rem <= '0;
            r_acc <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_op  <= op;
                r_sew <= vsew;
                r_us  <= us;
                r_rem <= vl;
                r_acc <= init_in & sewMask(vsew);
            end else if ((r_state == S_ACCUM) && lane_valid) begin
                r_acc <= w_accNext;
                r_rem <= w_remNext;
            end
        end
    end

    assign lane_ready   = r_laneReady;
    assign busy         = r_busy;
    assign result_valid = r_resultValid;
    assign result       = r_resultValid ? extendSew(r_acc, r_sew, r_us) : 32'd0;

endmodule

// File: tb/tb_scalar_reduce.sv
// tb_scalar_reduce: directed checks of scalar_reduce against
// hand-computed results.
module tb_scalar_reduce;

    localparam int MAX_VL = 64;
    localparam int VLW    = $clog2(MAX_VL + 1);

    logic            clk;
    logic            n_reset;
    logic            start;
    logic [2:0]      op;
    logic [1:0]      vsew;
    logic            us;
    logic [VLW-1:0]  vl;
    logic [31:0]     init_in;
    logic [127:0]    lane_data;
    logic            lane_valid;
    logic            lane_ready;
    logic            busy;
    logic [31:0]     result;
    logic            result_valid;
    logic            result_ready;

    int vectors;
    int miscompares;

    scalar_reduce #(.MAX_VL(MAX_VL)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (start),
        .op           (op),
        .vsew         (vsew),
        .us           (us),
        .vl           (vl),
        .init_in      (init_in),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of handshake inputs at a falling edge and returns at
    // the next falling edge, after the DUT has taken one rising edge.
    task automatic applyStimulus(input logic         s,
                                 input logic         lv,
                                 input logic [127:0] ld,
                                 input logic         rr);
        start        = s;
        lane_valid   = lv;
        lane_data    = ld;
        result_ready = rr;
        @(negedge clk);
    endtask

    // Compares one observed value with its expected value.
    task automatic checkOutput(input string       tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setConfig(input logic [2:0]     c_op,
                             input logic [1:0]     c_sew,
                             input logic           c_us,
                             input logic [VLW-1:0] c_vl,
                             input logic [31:0]    c_init);
        op      = c_op;
        vsew    = c_sew;
        us      = c_us;
        vl      = c_vl;
        init_in = c_init;
    endtask

    // Linear sequence of directed steps.
    initial begin
        vectors      = 0;
        miscompares  = 0;
        n_reset      = 1'b0;
        start        = 1'b0;
        lane_valid   = 1'b0;
        lane_data    = '0;
        result_ready = 1'b0;
        setConfig(3'd0, 2'd0, 1'b0, '0, 32'd0);
        repeat (2) @(negedge clk);

        checkOutput("rst_lane_ready", {31'd0, lane_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_result_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // Signed 8-bit sum over two beats, wrapping to 0x96
        setConfig(3'd0, 2'd0, 1'b0, VLW'(5), 32'h0000_0001);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("sum8_lane_ready", {31'd0, lane_ready}, 32'd1);
        checkOutput("sum8_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 1'b1,
                      {32'h1234_5603, 32'h0000_0002, 32'h0000_0001, 32'hABCD_EF7F}, 1'b0);
        checkOutput("sum8_mid_valid", {31'd0, result_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1,
                      {32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0010}, 1'b0);
        checkOutput("sum8_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("sum8_result", result, 32'hFFFF_FF96);
        checkOutput("sum8_done_lane_ready", {31'd0, lane_ready}, 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("sum8_idle_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("sum8_idle_busy", {31'd0, busy}, 32'd0);

        // 16-bit max, unsigned then signed
        setConfig(3'd4, 2'd1, 1'b1, VLW'(4), 32'hFFFF_0000);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1,
                      {32'h0000_0002, 32'hAAAA_7FFF, 32'h0000_0001, 32'h5555_8000}, 1'b0);
        checkOutput("max16u_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("max16u_result", result, 32'h0000_8000);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        setConfig(3'd4, 2'd1, 1'b0, VLW'(4), 32'hFFFF_0000);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1,
                      {32'h0000_0002, 32'hAAAA_7FFF, 32'h0000_0001, 32'h5555_8000}, 1'b0);
        checkOutput("max16s_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("max16s_result", result, 32'h0000_7FFF);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // vl == 0 returns init directly, beats offered are never taken
        setConfig(3'd4, 2'd2, 1'b0, VLW'(0), 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, {4{32'hFFFF_FFFF}}, 1'b0);
        checkOutput("vl0_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("vl0_result", result, 32'hDEAD_BEEF);
        checkOutput("vl0_lane_ready", {31'd0, lane_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, {4{32'hFFFF_FFFF}}, 1'b0);
        checkOutput("vl0_hold_lane_ready", {31'd0, lane_ready}, 32'd0);
        checkOutput("vl0_hold_result", result, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("vl0_idle_valid", {31'd0, result_valid}, 32'd0);

        // 32-bit xor with gapped beats and a stalled consumer
        setConfig(3'd3, 2'd2, 1'b0, VLW'(8), 32'h0F0F_0F0F);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            applyStimulus(1'b0, 1'b0, {4{32'hFFFF_FFFF}}, 1'b0);
            checkOutput("xor_gap_lane_ready", {31'd0, lane_ready}, 32'd1);
            checkOutput("xor_gap_valid", {31'd0, result_valid}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1,
                      {32'h8888_8888, 32'h4444_4444, 32'h2222_2222, 32'h1111_1111}, 1'b0);
        checkOutput("xor_beatA_valid", {31'd0, result_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, {4{32'h1357_2468}}, 1'b0);
        checkOutput("xor_gap2_valid", {31'd0, result_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1,
                      {32'h0000_0008, 32'h0000_0004, 32'h0000_0002, 32'h0000_0001}, 1'b0);
        checkOutput("xor_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("xor_result", result, 32'hF0F0_F0FF);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            checkOutput("xor_stall_valid", {31'd0, result_valid}, 32'd1);
            checkOutput("xor_stall_result", result, 32'hF0F0_F0FF);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("xor_idle_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("xor_idle_busy", {31'd0, busy}, 32'd0);

        // Reset after one of three beats abandons the reduction
        setConfig(3'd0, 2'd0, 1'b0, VLW'(12), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, {4{32'h0000_0001}}, 1'b0);
        start      = 1'b0;
        lane_valid = 1'b0;
        n_reset    = 1'b0;
        #1;
        checkOutput("midrst_lane_ready", {31'd0, lane_ready}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        setConfig(3'd5, 2'd0, 1'b1, VLW'(1), 32'h0000_0009);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1,
                      {32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005}, 1'b0);
        checkOutput("min8u_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("min8u_result", result, 32'h0000_0005);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // start held during DONE is ignored
        setConfig(3'd0, 2'd0, 1'b1, VLW'(4), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1,
                      {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 1'b0);
        checkOutput("hold_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("hold_result", result, 32'h0000_000A);
        setConfig(3'd3, 2'd2, 1'b0, VLW'(0), 32'h0000_0077);
        for (int h = 0; h < 2; h++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            checkOutput("hold_start_valid", {31'd0, result_valid}, 32'd1);
            checkOutput("hold_start_result", result, 32'h0000_000A);
            checkOutput("hold_start_busy", {31'd0, busy}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("hold_idle_valid", {31'd0, result_valid}, 32'd0);
        for (int q = 0; q < 2; q++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            checkOutput("hold_after_valid", {31'd0, result_valid}, 32'd0);
            checkOutput("hold_after_busy", {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
